bft_leaf_responder: RTL and testbench

BFT_LEAF_RESPONDER -- requirements
Module: bft_leaf_responder

---
 rtl/bft_pkg.sv | 39 +++
 rtl/bft_sync_fifo.sv | 60 ++++++
 rtl/bft_leaf_responder.sv | 134 +++++++++++++
 tb/tb_bft_leaf_responder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bft_pkg.sv
// +----------------------------------------------------------------------+
// | bft_pkg : shared BFT field constants, FSM state type and helpers     |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package bft_pkg;

  localparam int BFT_NUM_LEAVES = 8;
  localparam int BFT_L          = $clog2(BFT_NUM_LEAVES);
  localparam int BFT_D          = 4;
  localparam int BFT_P_SZ       = 1 + 2 * BFT_L + BFT_D;
  localparam int BFT_VALID_BIT  = BFT_P_SZ - 1;
  localparam int BFT_DEST_MSB   = BFT_P_SZ - 2;
  localparam int BFT_SRC_MSB    = BFT_P_SZ - 2 - BFT_L;
  localparam int BFT_DATA_MSB   = BFT_P_SZ - 2 - 2 * BFT_L;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_RETRY = 2'd2
  } bft_state_t;

  // Field offsets for an arbitrary packet width / leaf-address width.
  function automatic int dest_msb(input int p_sz);
    return p_sz - 2;
  endfunction

  function automatic int src_msb(input int p_sz, input int l);
    return p_sz - 2 - l;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bft_sync_fifo.sv
// +----------------------------------------------------------------------+
// | bft_sync_fifo : receive queue with push/pop and full/empty status    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module bft_sync_fifo #(
  parameter int width = 7,
  parameter int depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int            LF      = $clog2(depth);
  localparam logic [LF-1:0] PTR_ONE = LF'(1);
  localparam logic [LF:0]   CNT_ONE = (LF + 1)'(1);
  localparam logic [LF:0]   CNT_MAX = (LF + 1)'(depth);

  logic [width-1:0] mem [0:depth-1];
  logic [LF-1:0]    wr_ptr;
  logic [LF-1:0]    rd_ptr;
  logic [LF:0]      count;
  logic             do_push;
  logic             do_pop;

  // A push on a full queue is still taken when a pop frees a slot this cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (count == CNT_MAX);
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      count <= count + CNT_ONE;
      else if (do_pop && !do_push) count <= count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/bft_leaf_responder.sv
// +----------------------------------------------------------------------+
// | bft_leaf_responder : BFT leaf that queues requests and replies data+1 |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module bft_leaf_responder
  import bft_pkg::*;
#(
  parameter int num_leaves = BFT_NUM_LEAVES,
  parameter int payload_sz = $clog2(num_leaves) + 4,
  parameter int p_sz       = 1 + $clog2(num_leaves) + payload_sz,
  parameter int addr       = 1,
  parameter int fifo_depth = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [p_sz-1:0] interface_pe,
  input  logic            resend,
  output logic [p_sz-1:0] pe_interface,
  output logic [15:0]     rx_count,
  output logic [15:0]     tx_count,
  output logic [15:0]     drop_count,
  output logic            fifo_full,
  output logic            fifo_empty
);

  localparam int           L        = $clog2(num_leaves);
  localparam int           D        = p_sz - 1 - 2 * L;
  localparam int           QW       = L + D;
  localparam int           DEST_MSB = dest_msb(p_sz);
  localparam int           SRC_MSB  = src_msb(p_sz, L);
  localparam logic [L-1:0] ADDR_V   = L'(addr);
  localparam logic [D-1:0] DATA_ONE = D'(1);

  logic [p_sz-1:0] in_q;
  logic            in_valid;
  logic            for_me;
  logic            accept;
  logic            pop;
  logic [QW-1:0]   head;
  logic [p_sz-1:0] resp;
  logic [p_sz-1:0] pkt_n;
  logic [p_sz-1:0] held;
  logic [p_sz-1:0] held_n;
  logic            tx_inc;
  bft_state_t      state;
  bft_state_t      state_n;

  assign in_valid = in_q[p_sz-1];
  assign for_me   = in_valid && (in_q[DEST_MSB -: L] == ADDR_V);
  assign accept   = for_me && (!fifo_full || pop);
  assign resp     = {1'b1, head[QW-1 -: L], ADDR_V, head[D-1:0] + DATA_ONE};

  bft_sync_fifo #(
    .width (QW),
    .depth (fifo_depth)
  ) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (for_me),
    .pop   (pop),
    .din   (in_q[SRC_MSB:0]),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Incoming packets are captured first; this stage sets the 2-cycle issue latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_q       <= '0;
      rx_count   <= '0;
      tx_count   <= '0;
      drop_count <= '0;
    end else begin
      in_q <= interface_pe;
      if (accept)              rx_count   <= sat_inc(rx_count);
      if (in_valid && !accept) drop_count <= sat_inc(drop_count);
      if (tx_inc)              tx_count   <= sat_inc(tx_count);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      pe_interface <= '0;
      held         <= '0;
    end else begin
      state        <= state_n;
      pe_interface <= pkt_n;
      held         <= held_n;
    end
  end

  always_comb begin
    state_n = state;
    pkt_n   = '0;
    held_n  = held;
    pop     = 1'b0;
    tx_inc  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          pkt_n   = resp;
          held_n  = resp;
          state_n = ST_SEND;
        end
      end
      ST_SEND, ST_RETRY: begin
        if (resend) begin
          pkt_n   = held;
          state_n = ST_RETRY;
        end else begin
          // resend low means the packet on the wire was taken by the switch
          tx_inc = 1'b1;
          if (!fifo_empty) begin
            pop     = 1'b1;
            pkt_n   = resp;
            held_n  = resp;
            state_n = ST_SEND;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_bft_leaf_responder.sv
// +----------------------------------------------------------------------+
// | tb_bft_leaf_responder : directed + random checks against a queue model|
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_bft_leaf_responder;

  localparam int NL    = 8;
  localparam int L     = 3;
  localparam int D     = 4;
  localparam int P     = 11;
  localparam int ADDR  = 1;
  localparam int DEPTH = 4;

  logic           clk          = 1'b0;
  logic           reset        = 1'b1;
  logic           resend       = 1'b0;
  logic [P-1:0]   interface_pe = '0;
  logic [P-1:0]   pe_interface;
  logic [15:0]    rx_count;
  logic [15:0]    tx_count;
  logic [15:0]    drop_count;
  logic           fifo_full;
  logic           fifo_empty;

  int checks = 0;
  int errors = 0;

  // Transaction-level model: input stage, queue of {src,data}, wire packet, counts.
  logic [P-1:0]   m_stage;
  logic [P-1:0]   m_out;
  logic [L+D-1:0] m_q[$];
  int             m_rx;
  int             m_tx;
  int             m_drop;

  bft_leaf_responder #(
    .num_leaves (NL),
    .addr       (ADDR),
    .fifo_depth (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .interface_pe (interface_pe),
    .resend       (resend),
    .pe_interface (pe_interface),
    .rx_count     (rx_count),
    .tx_count     (tx_count),
    .drop_count   (drop_count),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty)
  );

  always #5 clk = ~clk;

  function automatic logic [P-1:0] mk(input int dest, input int src, input int data);
    return {1'b1, 3'(dest), 3'(src), 4'(data)};
  endfunction

  function automatic logic [P-1:0] response(input logic [L+D-1:0] e);
    logic [D-1:0] d;
    d = e[D-1:0] + 4'd1;
    return {1'b1, e[L+D-1 -: L], 3'(ADDR), d};
  endfunction

  function automatic int bump(input int v);
    return (v < 65535) ? v + 1 : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_stage = '0;
    m_out   = '0;
    m_q.delete();
    m_rx    = 0;
    m_tx    = 0;
    m_drop  = 0;
  endtask

  task automatic model_edge(input logic [P-1:0] pkt, input logic rs);
    if (m_out[P-1] && !rs) m_tx = bump(m_tx);
    if (!(m_out[P-1] && rs)) begin
      if (m_q.size() > 0) m_out = response(m_q.pop_front());
      else                m_out = '0;
    end
    if (m_stage[P-1]) begin
      if (m_stage[P-2 -: L] == 3'(ADDR) && m_q.size() < DEPTH) begin
        m_q.push_back(m_stage[L+D-1:0]);
        m_rx = bump(m_rx);
      end else begin
        m_drop = bump(m_drop);
      end
    end
    m_stage = pkt;
  endtask

  task automatic check_all();
    chk("pe_interface", 32'(pe_interface), 32'(m_out));
    chk("rx_count",     32'(rx_count),     32'(m_rx));
    chk("tx_count",     32'(tx_count),     32'(m_tx));
    chk("drop_count",   32'(drop_count),   32'(m_drop));
    chk("fifo_full",    32'(fifo_full),    32'(m_q.size() == DEPTH));
    chk("fifo_empty",   32'(fifo_empty),   32'(m_q.size() == 0));
  endtask

  // Drive at the falling edge, model the rising edge, check at the next falling edge.
  task automatic run_cycle(input logic [P-1:0] pkt, input logic rs);
    interface_pe = pkt;
    resend       = rs;
    @(posedge clk);
    model_edge(pkt, rs);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b1;
    interface_pe = '0;
    resend       = 1'b0;
    #1;
    chk("rst_pe",    32'(pe_interface), 32'd0);
    chk("rst_rx",    32'(rx_count),     32'd0);
    chk("rst_tx",    32'(tx_count),     32'd0);
    chk("rst_drop",  32'(drop_count),   32'd0);
    chk("rst_empty", 32'(fifo_empty),   32'd1);
    chk("rst_full",  32'(fifo_full),    32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [P-1:0] p;

    model_reset();
    do_reset();

    // Single request: response two cycles after sampling.
    run_cycle(mk(1, 5, 3), 1'b0);
    run_cycle('0, 1'b0);
    run_cycle('0, 1'b0);
    chk("single_resp", 32'(pe_interface), 32'(mk(5, 1, 4)));
    run_cycle('0, 1'b0);
    chk("single_tx", 32'(tx_count), 32'd1);
    chk("single_rx", 32'(rx_count), 32'd1);

    // Data wrap-around.
    do_reset();
    run_cycle(mk(1, 2, 15), 1'b0);
    run_cycle('0, 1'b0);
    run_cycle('0, 1'b0);
    chk("wrap_resp", 32'(pe_interface), 32'(mk(2, 1, 0)));
    run_cycle('0, 1'b0);

    // Wrong destination.
    do_reset();
    run_cycle(mk(3, 4, 7), 1'b0);
    repeat (3) run_cycle('0, 1'b0);
    chk("wrongdest_drop", 32'(drop_count),   32'd1);
    chk("wrongdest_rx",   32'(rx_count),     32'd0);
    chk("wrongdest_pe",   32'(pe_interface), 32'd0);

    // Overflow with the switch stalling.
    do_reset();
    for (int i = 0; i < 6; i++) run_cycle(mk(1, i, i + 8), 1'b1);
    repeat (4) run_cycle('0, 1'b1);
    chk("ovf_full",  32'(fifo_full),  32'd1);
    chk("ovf_rx",    32'(rx_count),   32'd5);
    chk("ovf_drop",  32'(drop_count), 32'd1);
    chk("ovf_total", 32'(rx_count) + 32'(drop_count), 32'd6);
    repeat (8) run_cycle('0, 1'b0);
    chk("ovf_tx", 32'(tx_count), 32'd5);

    // Retry: same packet held four cycles, then the next one.
    do_reset();
    run_cycle(mk(1, 6, 2), 1'b0);
    run_cycle(mk(1, 7, 9), 1'b0);
    run_cycle('0, 1'b0);
    chk("retry_first", 32'(pe_interface), 32'(mk(6, 1, 3)));
    for (int i = 0; i < 3; i++) begin
      run_cycle('0, 1'b1);
      chk("retry_held", 32'(pe_interface), 32'(mk(6, 1, 3)));
    end
    run_cycle('0, 1'b0);
    chk("retry_next", 32'(pe_interface), 32'(mk(7, 1, 10)));
    chk("retry_tx",   32'(tx_count),     32'd1);
    repeat (3) run_cycle('0, 1'b0);

    // Reset with packets still queued.
    do_reset();
    for (int i = 0; i < 4; i++) run_cycle(mk(1, i + 2, i), 1'b1);
    run_cycle('0, 1'b1);
    chk("midrst_queued", 32'(fifo_empty), 32'd0);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      run_cycle('0, 1'b0);
      chk("midrst_stale", 32'(pe_interface), 32'd0);
    end

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      p = 11'($urandom);
      p[P-1] = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) < 6) p[P-2 -: L] = 3'(ADDR);
      run_cycle(p, $urandom_range(0, 9) < 3);
    end
    repeat (12) run_cycle('0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
